// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong: double-buffered (ping-pong) pixel frame buffer, single clock domain.
// The producer writes the back bank while the display reads the front bank. Swap requests are
// deferred to the next frame_start so the display never tears.
//
// Optional clear engine, enabled by defining FB_CLEAR_EN: it fills the back bank with a constant
// colour, one pixel per cycle.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   we, wAddr, wData      pixel write into the back bank (~front_sel)
//   oe, rAddr, rData      pixel read from the front bank; rData is registered (1-cycle latency)
//   frame_start           one-cycle vsync pulse; the only point where a swap may happen
//   swap_req              one-cycle swap request pulse
//   swap_pending          request latched, waiting for frame_start
//   front_sel             displayed bank (0 = A, 1 = B)
//   clr_req, clr_color    start a clear of the back bank with clr_color (FB_CLEAR_EN only)
//   busy                  clear in progress (tied 0 without FB_CLEAR_EN)
module frame_buffer_pingpong #(
    parameter int unsigned H_RES  = 160,
    parameter int unsigned V_RES  = 120,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic              oe,
    input  logic [ADDR_W-1:0] rAddr,
    output logic [DATA_W-1:0] rData,
    input  logic              frame_start,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              front_sel,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    output logic              busy
);

    localparam int unsigned DEPTH = H_RES * V_RES;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    logic              w_in_range;
    logic              r_in_range;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              swap_ok;

    // Compare in 32 bits so a power-of-two DEPTH cannot wrap to zero.
    assign w_in_range = 32'(wAddr) < DEPTH;
    assign r_in_range = 32'(rAddr) < DEPTH;

`ifdef FB_CLEAR_EN
    typedef enum logic {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_color_q, clr_color_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        wr_en       = 1'b0;
        wr_addr     = wAddr;
        wr_data     = wData;
        case (state_q)
            StIdle: begin
                if (clr_req) begin
                    // clr_req wins over a same-cycle we; that write is dropped.
                    state_d     = StClear;
                    clr_cnt_d   = '0;
                    clr_color_d = clr_color;
                end else begin
                    wr_en = we & w_in_range;
                end
            end
            StClear: begin
                wr_en   = 1'b1;
                wr_addr = clr_cnt_q;
                wr_data = clr_color_q;
                if (32'(clr_cnt_q) == DEPTH - 1) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Swaps are held pending for the whole clear.
    assign swap_ok = frame_start & (swap_req | swap_pending) & (state_q == StIdle);
    assign busy    = (state_q == StClear);
`else
    logic unused_clr;
    assign unused_clr = ^{clr_req, clr_color};

    assign wr_en   = we & w_in_range;
    assign wr_addr = wAddr;
    assign wr_data = wData;
    assign swap_ok = frame_start & (swap_req | swap_pending);
    assign busy    = 1'b0;
`endif

    // Pixel storage is never reset; writes always land in the back bank.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (front_sel) begin
                mem_a[wr_addr] <= wr_data;
            end else begin
                mem_b[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rData        <= '0;
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (oe) begin
                if (!r_in_range) begin
                    rData <= '0;
                end else if (front_sel) begin
                    rData <= mem_b[rAddr];
                end else begin
                    rData <= mem_a[rAddr];
                end
            end
            // A swap_req arriving with frame_start swaps at once; extra requests are absorbed.
            if (swap_ok) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
module tb_frame_buffer_pingpong;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DEPTH  = 19200;
    localparam int          NV     = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic              oe;
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rData;
    logic              frame_start;
    logic              swap_req;
    logic              swap_pending;
    logic              front_sel;
    logic              clr_req;
    logic [DATA_W-1:0] clr_color;
    logic              busy;

    always #5 clk = ~clk;

    frame_buffer_pingpong dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .wAddr        (wAddr),
        .wData        (wData),
        .oe           (oe),
        .rAddr        (rAddr),
        .rData        (rData),
        .frame_start  (frame_start),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel),
        .clr_req      (clr_req),
        .clr_color    (clr_color),
        .busy         (busy)
    );

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              oe;
        logic [ADDR_W-1:0] raddr;
        logic              fstart;
        logic              sreq;
        logic [DATA_W-1:0] exp_rdata;
        logic              exp_front;
        logic              exp_pend;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we          = 1'b0;
        wAddr       = '0;
        wData       = '0;
        oe          = 1'b0;
        rAddr       = '0;
        frame_start = 1'b0;
        swap_req    = 1'b0;
        clr_req     = 1'b0;
        clr_color   = '0;
    endtask

    task automatic read_check(input string name, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] exp);
        oe    = 1'b1;
        rAddr = a;
        tick();
        oe = 1'b0;
        check(name, 32'(rData), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // we, waddr, wdata, oe, raddr, fstart, sreq, exp_rdata, exp_front, exp_pend
        vecs[0]  = '{1'b1, 15'd5,     16'h1234, 1'b0, 15'd0,     1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 15'd6,     16'hBEEF, 1'b0, 15'd0,     1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 15'd0,     16'h0F0F, 1'b0, 15'd0,     1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 15'd0,     16'h0000, 1'b0, 15'd0,     1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 15'd0,     16'h0000, 1'b1, 15'd5,     1'b0, 1'b0, 16'h1234, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 15'd0,     16'h0000, 1'b1, 15'd6,     1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 15'd0,     16'h0000, 1'b0, 15'd5,     1'b0, 1'b0, 16'hBEEF, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 15'd5,     16'hAAAA, 1'b1, 15'd20000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 15'd0,     16'h0C0C, 1'b0, 15'd0,     1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 15'd19200, 16'hDEAD, 1'b1, 15'd0,     1'b0, 1'b0, 16'h0F0F, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 15'd0,     16'h0000, 1'b1, 15'd0,     1'b1, 1'b0, 16'h0F0F, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 15'd0,     16'h0000, 1'b1, 15'd6,     1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 15'd0,     16'h0000, 1'b1, 15'd5,     1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 15'd0,     16'h0000, 1'b1, 15'd0,     1'b0, 1'b0, 16'h0C0C, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 15'd0,     16'h0000, 1'b1, 15'd32767, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset rData", 32'(rData), 32'h0);
        check("reset front_sel", 32'(front_sel), 32'h0);
        check("reset swap_pending", 32'(swap_pending), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        reset = 1'b0;
        tick();

        // Table-driven single-cycle vectors.
        for (int i = 0; i < NV; i++) begin
            we          = vecs[i].we;
            wAddr       = vecs[i].waddr;
            wData       = vecs[i].wdata;
            oe          = vecs[i].oe;
            rAddr       = vecs[i].raddr;
            frame_start = vecs[i].fstart;
            swap_req    = vecs[i].sreq;
            tick();
            check($sformatf("vec%0d rData", i), 32'(rData), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d front_sel", i), 32'(front_sel), 32'(vecs[i].exp_front));
            check($sformatf("vec%0d swap_pending", i), 32'(swap_pending), 32'(vecs[i].exp_pend));
        end
        idle_inputs();

        // swap_req at cycles 10 and 20, frame_start at cycle 50: exactly one toggle.
        for (int c = 1; c <= 60; c++) begin
            swap_req    = (c == 10) || (c == 20);
            frame_start = (c == 50);
            tick();
            check($sformatf("defer c%0d swap_pending", c), 32'(swap_pending),
                  (c >= 10 && c < 50) ? 32'h1 : 32'h0);
            check($sformatf("defer c%0d front_sel", c), 32'(front_sel),
                  (c >= 50) ? 32'h1 : 32'h0);
        end
        idle_inputs();

`ifdef FB_CLEAR_EN
        begin : clear_tests
            int busy_cycles;
            // front = 1, so bank A is cleared. Same-cycle we must be dropped.
            clr_req   = 1'b1;
            clr_color = 16'hF800;
            we        = 1'b1;
            wAddr     = 15'd3;
            wData     = 16'h5555;
            tick();
            idle_inputs();
            check("clear busy rise", 32'(busy), 32'h1);
            busy_cycles = 1;
            for (int i = 0; i < 20000; i++) begin
                swap_req    = (i == 50);
                frame_start = (i == 50);
                we          = (i == 60);
                wAddr       = 15'd4;
                wData       = 16'h7777;
                tick();
                if (!busy) break;
                busy_cycles++;
            end
            idle_inputs();
            check("clear busy cycles", 32'(busy_cycles), 32'(DEPTH));
            check("clear front held", 32'(front_sel), 32'h1);
            check("clear swap held pending", 32'(swap_pending), 32'h1);
            // First cycle after busy falls: write accepted.
            we    = 1'b1;
            wAddr = 15'd9;
            wData = 16'h0A0A;
            tick();
            idle_inputs();
            check("post-clear no spurious swap", 32'(front_sel), 32'h1);
            frame_start = 1'b1;
            tick();
            idle_inputs();
            check("post-clear swap fires", 32'(front_sel), 32'h0);
            check("post-clear pending clr", 32'(swap_pending), 32'h0);
            read_check("clear addr0", 15'd0, 16'hF800);
            read_check("clear addr3 (dropped we)", 15'd3, 16'hF800);
            read_check("clear addr4 (we ignored)", 15'd4, 16'hF800);
            read_check("clear addr9599", 15'd9599, 16'hF800);
            read_check("clear addr19199", 15'd19199, 16'hF800);
            read_check("we after busy fall", 15'd9, 16'h0A0A);

            // Reset in the middle of a clear of bank B at pixel 100.
            we    = 1'b1;
            wAddr = 15'd99;
            wData = 16'h1111;
            tick();
            wAddr = 15'd100;
            wData = 16'h2222;
            tick();
            idle_inputs();
            clr_req   = 1'b1;
            clr_color = 16'h07E0;
            tick();
            idle_inputs();
            for (int k = 1; k <= 100; k++) begin
                swap_req = (k == 5);
                oe       = 1'b1;
                rAddr    = 15'd0;
                tick();
            end
            idle_inputs();
            check("midclear busy", 32'(busy), 32'h1);
            check("midclear pending", 32'(swap_pending), 32'h1);
            check("midclear read", 32'(rData), 32'hF800);
            reset = 1'b1;
            #1;
            check("async reset busy", 32'(busy), 32'h0);
            check("async reset pending", 32'(swap_pending), 32'h0);
            check("async reset rData", 32'(rData), 32'h0);
            check("async reset front_sel", 32'(front_sel), 32'h0);
            @(posedge clk);
            #1;
            reset = 1'b0;
            frame_start = 1'b1;
            tick();
            idle_inputs();
            check("pending lost after reset", 32'(front_sel), 32'h0);
            swap_req    = 1'b1;
            frame_start = 1'b1;
            tick();
            idle_inputs();
            check("swap to partial bank", 32'(front_sel), 32'h1);
            check("busy stays low", 32'(busy), 32'h0);
            read_check("partial addr99", 15'd99, 16'h07E0);
            read_check("partial addr100", 15'd100, 16'h2222);
        end
`else
        // Without the clear engine clr_req is ignored and we is always accepted.
        clr_req   = 1'b1;
        clr_color = 16'hF800;
        we        = 1'b1;
        wAddr     = 15'd7;
        wData     = 16'h3C3C;
        tick();
        idle_inputs();
        check("noclear busy", 32'(busy), 32'h0);
        swap_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        idle_inputs();
        check("noclear swap", 32'(front_sel), 32'h0);
        read_check("noclear we accepted", 15'd7, 16'h3C3C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
